// File: rtl/user_au_pkg.sv
// Shared types and I2S frame constants for the audio output path.
package user_au_pkg;

  typedef logic signed [31:0] sample_t;

  localparam int FrameSlots   = 64;
  localparam int LeftMsbSlot  = 1;
  localparam int RightMsbSlot = 33;

endpackage

// File: rtl/user_au_sck_gen.sv
// I2S bit-clock divider: toggles sck every ClkDiv clk cycles and flags the falling edge.
module user_au_sck_gen #(
  parameter int ClkDiv = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  output logic sck_o,
  output logic fall_o
);

  localparam int CntW = (ClkDiv > 1) ? $clog2(ClkDiv) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            sck_q, sck_d;
  logic            tc;

  always_comb begin
    tc    = (cnt_q == CntW'(ClkDiv - 1));
    cnt_d = tc ? '0 : cnt_q + 1'b1;
    sck_d = sck_q ^ tc;
    if (!en_i) begin
      cnt_d = '0;
      sck_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      sck_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sck_q <= sck_d;
    end
  end

  // Strobe is high in the cycle whose closing edge drives sck low.
  assign fall_o = en_i & tc & sck_q;
  assign sck_o  = sck_q;

endmodule

// File: rtl/user_au_i2s_tx.sv
// I2S controller-mode transmitter: one mono sample per frame, sent on both channels.
module user_au_i2s_tx
  import user_au_pkg::*;
#(
  parameter int ClkDiv      = 4,
  parameter int SampleWidth = 32
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          en_i,
  input  logic signed [SampleWidth-1:0] data_i,
  input  logic                          valid_i,
  output logic                          ready_o,
  output logic                          sck_o,
  output logic                          ws_o,
  output logic                          sd_o,
  output logic                          underrun_o
);

  localparam int SlotW = $clog2(FrameSlots);

  logic [SlotW-1:0]              slot_q, slot_d;
  logic signed [SampleWidth-1:0] hold_q, hold_d;
  logic signed [SampleWidth-1:0] shift_q, shift_d;
  logic                          hold_valid_q, hold_valid_d;
  logic                          ws_q, ws_d;
  logic                          sd_q, sd_d;
  logic                          underrun_q, underrun_d;
  logic                          sck_fall;
  logic                          load;

  user_au_sck_gen #(
    .ClkDiv(ClkDiv)
  ) u_sck_gen (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .en_i  (en_i),
    .sck_o (sck_o),
    .fall_o(sck_fall)
  );

  assign ready_o = !hold_valid_q;

  always_comb begin
    slot_d       = slot_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    shift_d      = shift_q;
    ws_d         = ws_q;
    sd_d         = sd_q;
    underrun_d   = 1'b0;
    load         = 1'b0;

    if (!en_i) begin
      slot_d  = '0;
      shift_d = '0;
      ws_d    = 1'b0;
      sd_d    = 1'b0;
    end else if (sck_fall) begin
      slot_d = (slot_q == SlotW'(FrameSlots - 1)) ? '0 : slot_q + 1'b1;
      ws_d   = (slot_d >= SlotW'(RightMsbSlot - 1));
      if (slot_d == SlotW'(LeftMsbSlot)) begin
        load       = 1'b1;
        shift_d    = hold_valid_q ? hold_q : '0;
        underrun_d = !hold_valid_q;
      end else begin
        // Rotating keeps the sample intact so the right slot replays it.
        shift_d = {shift_q[SampleWidth-2:0], shift_q[SampleWidth-1]};
      end
      sd_d = shift_d[SampleWidth-1];
    end

    if (load) begin
      hold_valid_d = 1'b0;
    end
    if (valid_i && ready_o) begin
      hold_valid_d = 1'b1;
      hold_d       = data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      slot_q       <= '0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      shift_q      <= '0;
      ws_q         <= 1'b0;
      sd_q         <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      slot_q       <= slot_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      shift_q      <= shift_d;
      ws_q         <= ws_d;
      sd_q         <= sd_d;
      underrun_q   <= underrun_d;
    end
  end

  assign ws_o       = ws_q;
  assign sd_o       = sd_q;
  assign underrun_o = underrun_q;

endmodule
